// File: rtl/place_pkg.sv
// Shared placement constants and types: strike code, strip y-base table and decode helper.
package place_pkg;

    typedef logic [3:0] strip_id_t;
    typedef logic [7:0] index_t;

    localparam index_t STRIKE_IDX = 8'd128;
    localparam int     NUM_STRIPS = 13;

    localparam index_t STRIP_Y_BASE [1:NUM_STRIPS] = '{
        8'd0,  8'd8,  8'd16, 8'd25, 8'd32, 8'd42, 8'd48,
        8'd59, 8'd64, 8'd76, 8'd80, 8'd96, 8'd112
    };

    typedef struct packed {
        strip_id_t strip_id;
        index_t    width;
        logic      strike;
        logic      invalid;
    } result_t;

    // Strike code wins over the table; anything unmatched is flagged invalid.
    function automatic result_t decode_place(input index_t x, input index_t y,
                                             input logic hit, input strip_id_t id);
        result_t r;
        r = '0;
        if ((x == STRIKE_IDX) && (y == STRIKE_IDX)) begin
            r.strike = 1'b1;
        end else if (hit && (x < STRIKE_IDX)) begin
            r.strip_id = id;
            r.width    = x;
        end else begin
            r.invalid = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/find_strip_if.sv
// Handshake bus for find_strip: placed coordinates in, decoded strip result out.
interface find_strip_if;
    import place_pkg::*;

    logic      in_valid;
    logic      in_ready;
    index_t    x_in;
    index_t    y_in;
    logic      out_valid;
    logic      out_ready;
    strip_id_t strip_ID_out;
    index_t    occupied_width_out;
    logic      strike_flag_out;
    logic      invalid_flag_out;

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, strip_ID_out, occupied_width_out,
               strike_flag_out, invalid_flag_out
    );

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, strip_ID_out, occupied_width_out,
               strike_flag_out, invalid_flag_out
    );
endinterface

// File: rtl/strip_y_lookup.sv
// Combinational y -> strip ID lookup against the exact base table.
module strip_y_lookup
    import place_pkg::*;
(
    input  index_t    y,
    output logic      hit,
    output strip_id_t strip_id
);

    // Exact-match scan; bases are unique so at most one entry hits.
    always_comb begin
        hit      = 1'b0;
        strip_id = 4'd0;
        for (int i = 1; i <= NUM_STRIPS; i++) begin
            if (y == STRIP_Y_BASE[i]) begin
                hit      = 1'b1;
                strip_id = strip_id_t'(i);
            end else begin
                hit      = hit;
            end
        end
    end

endmodule

// File: rtl/find_strip.sv
// Two-stage valid/ready decoder from placed (x, y) back to strip ID / width / strike.
// Optional saturating strike/invalid counters under FIND_STRIP_ERR_CNT_EN.
module find_strip
    import place_pkg::*;
`ifdef FIND_STRIP_ERR_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
`ifdef FIND_STRIP_ERR_CNT_EN
    output logic [CNT_W-1:0] strike_cnt,
    output logic [CNT_W-1:0] invalid_cnt,
`endif
    find_strip_if.slave bus
);

    logic      alive_r;
    logic      s1_valid_r;
    index_t    x_r;
    index_t    y_r;
    logic      out_valid_r;
    result_t   res_r;
    logic      s2_load_s;
    logic      in_ready_s;
    logic      hit_s;
    strip_id_t id_s;
    result_t   dec_s;

    // in_ready is held low until the first clock after reset release.
    assign s2_load_s  = s1_valid_r && (!out_valid_r || bus.out_ready);
    assign in_ready_s = alive_r && (!s1_valid_r || s2_load_s);

    strip_y_lookup u_lookup (
        .y        (y_r),
        .hit      (hit_s),
        .strip_id (id_s)
    );

    assign dec_s = decode_place(x_r, y_r, hit_s, id_s);

    // Out-of-reset enable for in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
        end
    end

    // Stage 1: capture coordinates on an input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            x_r        <= 8'd0;
            y_r        <= 8'd0;
        end else if (bus.in_valid && in_ready_s) begin
            s1_valid_r <= 1'b1;
            x_r        <= bus.x_in;
            y_r        <= bus.y_in;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: registered decoded result feeding the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            res_r       <= '0;
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            res_r       <= dec_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready           = in_ready_s;
    assign bus.out_valid          = out_valid_r;
    assign bus.strip_ID_out       = res_r.strip_id;
    assign bus.occupied_width_out = res_r.width;
    assign bus.strike_flag_out    = res_r.strike;
    assign bus.invalid_flag_out   = res_r.invalid;

`ifdef FIND_STRIP_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating event counters, stepped on output handshakes only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strike_cnt  <= '0;
            invalid_cnt <= '0;
        end else if (out_valid_r && bus.out_ready) begin
            if (res_r.strike && (strike_cnt != CNT_MAX)) begin
                strike_cnt <= strike_cnt + CNT_ONE;
            end else begin
                strike_cnt <= strike_cnt;
            end
            if (res_r.invalid && (invalid_cnt != CNT_MAX)) begin
                invalid_cnt <= invalid_cnt + CNT_ONE;
            end else begin
                invalid_cnt <= invalid_cnt;
            end
        end else begin
            strike_cnt  <= strike_cnt;
            invalid_cnt <= invalid_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_find_strip.sv
// Scoreboard bench for find_strip: driver pushes expected results, monitor pops on output handshakes.
module tb_find_strip;

    logic clk;
    logic rst;

    find_strip_if bus ();

`ifdef FIND_STRIP_ERR_CNT_EN
    logic [1:0] strike_cnt;
    logic [1:0] invalid_cnt;

    find_strip #(.CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .strike_cnt  (strike_cnt),
        .invalid_cnt (invalid_cnt),
        .bus         (bus)
    );
`else
    find_strip dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] w;
        logic       s;
        logic       i;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic in_stream = 1'b0;
    logic saw_block = 1'b0;
    logic hold_r    = 1'b0;
    exp_t held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t cur_out();
        exp_t e;
        e.id = bus.strip_ID_out;
        e.w  = bus.occupied_width_out;
        e.s  = bus.strike_flag_out;
        e.i  = bus.invalid_flag_out;
        return e;
    endfunction

    // Monitor: stability while stalled, scoreboard pop on each output handshake.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (hold_r) begin
                check("stall_stable_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_stable_data", {18'd0, cur_out()}, {18'd0, held});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", {18'd0, cur_out()}, 32'hFFFF_FFFF);
                end else begin
                    check("result", {18'd0, cur_out()}, {18'd0, sbq.pop_front()});
                end
            end
            hold_r = bus.out_valid && !bus.out_ready;
            held   = cur_out();
            if (in_stream && bus.in_valid && !bus.in_ready) saw_block = 1'b1;
        end else begin
            hold_r = 1'b0;
        end
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] id, input logic [7:0] w, input logic s, input logic i);
        int n = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.y_in     = y;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            e.id = id; e.w = w; e.s = s; e.i = i;
            sbq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || bus.out_valid) && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 100) check("drain_timeout", sbq.size(), 32'd0);
    endtask

    logic [7:0] ybase [13] = '{8'd0, 8'd8, 8'd16, 8'd25, 8'd32, 8'd42, 8'd48,
                               8'd59, 8'd64, 8'd76, 8'd80, 8'd96, 8'd112};

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x_in      = 8'd0;
        bus.y_in      = 8'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("reset_outputs", {18'd0, cur_out()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Two-cycle latency on the first item.
        send(8'd5, 8'd25, 4'd4, 8'd5, 1'b0, 1'b0);
        #1;
        check("latency_c1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("latency_c2", {31'd0, bus.out_valid}, 32'd1);
        drain();

        send(8'd128, 8'd128, 4'd0, 8'd0,   1'b1, 1'b0);
        send(8'd3,   8'd26,  4'd0, 8'd0,   1'b0, 1'b1);
        send(8'd128, 8'd0,   4'd0, 8'd0,   1'b0, 1'b1);
        send(8'd128, 8'd5,   4'd0, 8'd0,   1'b0, 1'b1);
        send(8'd127, 8'd112, 4'd13, 8'd127, 1'b0, 1'b0);
        send(8'd0,   8'd0,   4'd1, 8'd0,   1'b0, 1'b0);
        drain();
`ifdef FIND_STRIP_ERR_CNT_EN
        check("strike_cnt_1", {30'd0, strike_cnt}, 32'd1);
        check("invalid_cnt_3", {30'd0, invalid_cnt}, 32'd3);
        send(8'd1, 8'd130, 4'd0, 8'd0, 1'b0, 1'b1);
        send(8'd7, 8'd200, 4'd0, 8'd0, 1'b0, 1'b1);
        drain();
        check("invalid_cnt_sat", {30'd0, invalid_cnt}, 32'd3);
        check("strike_cnt_hold", {30'd0, strike_cnt}, 32'd1);
`endif

        // Back-to-back stream of all 13 strips with a 3-cycle downstream stall.
        in_stream = 1'b1;
        fork
            begin
                for (int k = 0; k < 13; k++) begin
                    send(8'(9 * (k + 1)), ybase[k], 4'(k + 1), 8'(9 * (k + 1)), 1'b0, 1'b0);
                end
            end
            begin
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        in_stream = 1'b0;
        check("stall_in_ready_low", {31'd0, saw_block}, 32'd1);

        // Reset with two items in flight.
        bus.out_ready = 1'b0;
        send(8'd2, 8'd8,  4'd2, 8'd2, 1'b0, 1'b0);
        send(8'd4, 8'd16, 4'd3, 8'd4, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);

        send(8'd9, 8'd64, 4'd9, 8'd9, 1'b0, 1'b0);
        drain();
        check("scoreboard_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
